wt_store_buffer: RTL and testbench
==================================

WT_STORE_BUFFER -- requirements
Module: wt_store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, buffer entries (power of two, 2..16).
REQ-002 SHALL have parameter TID_W, default 2, memory transaction-ID width; max outstanding = 2**TID_W.
REQ-003 SHALL have port clk_i, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have port st_valid_i / st_ready_o, input/output, 1/1, store request handshake.
REQ-006 SHALL have port st_addr_i, input, 64, byte address; bits [2:0] ignored (word = addr[63:3]).
REQ-007 SHALL have port st_data_i / st_be_i, input, 64/8, store data and byte enables.
REQ-008 SHALL have port mem_valid_o / mem_ready_i, output/input, 1/1, memory write handshake.
REQ-009 SHALL have port mem_addr_o / mem_data_o / mem_be_o / mem_tid_o, output, 64/64/8/TID_W, write payload; mem_addr_o[2:0]=0.
REQ-010 SHALL have port mem_rsp_valid_i / mem_rsp_tid_i, input, 1/TID_W, write acknowledge.
REQ-011 SHALL have port chk_addr_i / chk_hit_o, input/output, 64/1, load-hazard probe.
REQ-012 SHALL have port empty_o / full_o, output, 1/1, occupancy status.

Function
REQ-013 Each entry SHALL hold state FREE, PEND (not yet sent), SENT (awaiting ack) or DONE (acked, not retired), plus word address, data, be, tid.
REQ-014 Entries SHALL form a circular FIFO with tail (allocate), issue and head (retire) pointers, each log2(DEPTH) bits, wrapping DEPTH-1 -> 0, plus count 0..DEPTH.
REQ-015 st_ready_o SHALL equal (count != DEPTH), independent of merge possibility.
REQ-016 On st_valid_i & st_ready_o, if a PEND entry has equal word address and is not currently driving mem_valid_o, the store SHALL merge: data bytes with be=1 overwritten, be := be | st_be_i; count unchanged.
REQ-017 Otherwise the store SHALL allocate the entry at tail as PEND with its data/be; tail+1, count+1.
REQ-018 At most one PEND entry SHALL exist per word address (guaranteed by REQ-016).
REQ-019 mem_valid_o SHALL be 1 when entry at issue pointer is PEND and at least one TID is free; payload from that entry, mem_tid_o = lowest free TID.
REQ-020 Once mem_valid_o is 1, payload and mem_tid_o SHALL remain stable until mem_ready_i.
REQ-021 On mem_valid_o & mem_ready_i, the entry SHALL become SENT, record the TID, mark TID busy, issue pointer +1.
REQ-022 On mem_rsp_valid_i with busy TID t, the SENT entry holding t SHALL become DONE and t freed; a response with non-busy TID SHALL be ignored.
REQ-023 When entry at head is DONE it SHALL become FREE, head+1, count-1 (one retire per cycle); acks may arrive out of order, retirement is in order.
REQ-024 Simultaneous allocate and retire SHALL leave count unchanged; a TID freed and reallocated in the same cycle SHALL be permitted.
REQ-025 chk_hit_o SHALL be combinational: 1 iff any PEND or SENT entry's word address equals chk_addr_i[63:3].
REQ-026 empty_o = (count==0); full_o = (count==DEPTH).
REQ-027 Store-to-memory latency SHALL be at least 1 cycle: a store accepted in cycle N drives mem_valid_o no earlier than N+1.

Reset
REQ-028 While rst_i=1, all entries SHALL be FREE, pointers and count 0, all TIDs free.
REQ-029 During reset: st_ready_o=1, mem_valid_o=0, mem_addr_o/data/be/tid=0, chk_hit_o=0, empty_o=1, full_o=0.
REQ-030 Reset asserted mid-operation SHALL discard all entries, including SENT ones; later acks for discarded TIDs are ignored per REQ-022.

Verification
REQ-031 Single store addr 0x8000_0010, data 0x11, be 0x01, mem_ready_i=1 -> mem_valid_o in next cycle with addr 0x8000_0010, tid 0; ack tid 0 -> empty_o=1 two cycles later.
REQ-032 mem_ready_i=0; stores to 0x100 be 0x0F then 0x104 be 0xF0 -> entry 0x100 if not yet presented merges, else second entry; with mem_valid_o already high, payload be stays 0x0F and count=2.
REQ-033 mem_ready_i=0, 8 stores to distinct words -> full_o=1, st_ready_o=0; 9th held; one ack-and-retire -> st_ready_o=1.
REQ-034 Issue 4 writes (tids 0..3), ack order 2,0,3,1 -> mem_valid_o blocked after 4 issues until ack; head retires only after tid 0 acked; retire order entries 0,1,2,3.
REQ-035 Pending store to 0x2000 -> chk_addr_i=0x2007 gives chk_hit_o=1, 0x2008 gives 0; after retire, 0.
REQ-036 Reset with 3 SENT entries, then ack tid 1 -> ignored, empty_o=1, mem_valid_o=0.

Source files
------------

// File: rtl/wt_store_buffer.sv
// Write-through store buffer: merges stores into not-yet-presented entries,
// issues to memory in order with tagged IDs, and retires in order on acks.
module wt_store_buffer #(
  parameter int DEPTH = 8,
  parameter int TID_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             st_valid_i,
  output logic             st_ready_o,
  input  logic [63:0]      st_addr_i,
  input  logic [63:0]      st_data_i,
  input  logic [7:0]       st_be_i,
  output logic             mem_valid_o,
  input  logic             mem_ready_i,
  output logic [63:0]      mem_addr_o,
  output logic [63:0]      mem_data_o,
  output logic [7:0]       mem_be_o,
  output logic [TID_W-1:0] mem_tid_o,
  input  logic             mem_rsp_valid_i,
  input  logic [TID_W-1:0] mem_rsp_tid_i,
  input  logic [63:0]      chk_addr_i,
  output logic             chk_hit_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int NT = 2**TID_W;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {FREE, PEND, SENT, DONE} ent_e;

  ent_e             r_st    [DEPTH];
  logic [60:0]      r_waddr [DEPTH];
  logic [63:0]      r_data  [DEPTH];
  logic [7:0]       r_be    [DEPTH];
  logic [TID_W-1:0] r_tid   [DEPTH];
  logic [PW-1:0]    r_tail, r_iss, r_head;
  logic [PW:0]      r_count;
  logic [NT-1:0]    r_busy;
  logic             r_hold;
  logic [TID_W-1:0] r_hold_tid;

  logic             w_mvalid, w_fire, w_acc, w_mhit, w_merge, w_alloc, w_rsp_ok, w_retire;
  logic [PW-1:0]    w_midx;
  logic [TID_W-1:0] w_low_free, w_tid;
  logic [NT-1:0]    w_set, w_clr;
  logic             w_unused;

  assign w_unused = ^{st_addr_i[2:0], chk_addr_i[2:0]};

  always_comb begin
    w_low_free = '0;
    for (int t = NT-1; t >= 0; t--)
      if (!r_busy[t]) w_low_free = TID_W'(t);
  end

  // A presented-but-stalled write keeps its TID even if a lower one frees up.
  assign w_tid    = r_hold ? r_hold_tid : w_low_free;
  assign w_mvalid = (r_st[r_iss] == PEND) && !(&r_busy);
  assign w_fire   = w_mvalid && mem_ready_i;

  assign st_ready_o = (r_count != FULL_CNT);
  assign w_acc      = st_valid_i && st_ready_o;

  always_comb begin
    w_mhit = 1'b0;
    w_midx = '0;
    for (int i = 0; i < DEPTH; i++)
      if (r_st[i] == PEND && r_waddr[i] == st_addr_i[63:3] &&
          !(w_mvalid && PW'(i) == r_iss)) begin
        w_mhit = 1'b1;
        w_midx = PW'(i);
      end
  end

  assign w_merge  = w_acc && w_mhit;
  assign w_alloc  = w_acc && !w_mhit;
  assign w_rsp_ok = mem_rsp_valid_i && r_busy[mem_rsp_tid_i];
  assign w_retire = (r_st[r_head] == DONE);
  assign w_set    = w_fire   ? (NT'(1) << w_tid)         : '0;
  assign w_clr    = w_rsp_ok ? (NT'(1) << mem_rsp_tid_i) : '0;

  always_comb begin
    chk_hit_o = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if ((r_st[i] == PEND || r_st[i] == SENT) && r_waddr[i] == chk_addr_i[63:3])
        chk_hit_o = 1'b1;
  end

  assign mem_valid_o = w_mvalid;
  assign mem_addr_o  = w_mvalid ? {r_waddr[r_iss], 3'b000} : '0;
  assign mem_data_o  = w_mvalid ? r_data[r_iss] : '0;
  assign mem_be_o    = w_mvalid ? r_be[r_iss]   : '0;
  assign mem_tid_o   = w_mvalid ? w_tid         : '0;
  assign empty_o     = (r_count == '0);
  assign full_o      = (r_count == FULL_CNT);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_st[i]    <= FREE;
        r_waddr[i] <= '0;
        r_data[i]  <= '0;
        r_be[i]    <= '0;
        r_tid[i]   <= '0;
      end
      r_tail     <= '0;
      r_iss      <= '0;
      r_head     <= '0;
      r_count    <= '0;
      r_busy     <= '0;
      r_hold     <= 1'b0;
      r_hold_tid <= '0;
    end else begin
      if (w_merge) begin
        for (int b = 0; b < 8; b++)
          if (st_be_i[b]) r_data[w_midx][b*8 +: 8] <= st_data_i[b*8 +: 8];
        r_be[w_midx] <= r_be[w_midx] | st_be_i;
      end
      if (w_alloc) begin
        r_st[r_tail]    <= PEND;
        r_waddr[r_tail] <= st_addr_i[63:3];
        r_data[r_tail]  <= st_data_i;
        r_be[r_tail]    <= st_be_i;
        r_tail          <= r_tail + PW'(1);
      end
      if (w_fire) begin
        r_st[r_iss]  <= SENT;
        r_tid[r_iss] <= w_tid;
        r_iss        <= r_iss + PW'(1);
      end
      if (w_rsp_ok)
        for (int i = 0; i < DEPTH; i++)
          if (r_st[i] == SENT && r_tid[i] == mem_rsp_tid_i) r_st[i] <= DONE;
      if (w_retire) begin
        r_st[r_head] <= FREE;
        r_head       <= r_head + PW'(1);
      end
      r_busy     <= (r_busy | w_set) & ~w_clr;
      r_count    <= r_count + (PW+1)'(w_alloc) - (PW+1)'(w_retire);
      r_hold     <= w_mvalid && !mem_ready_i;
      r_hold_tid <= w_tid;
    end
  end
endmodule

// File: tb/tb_wt_store_buffer.sv
// Bench for wt_store_buffer: directed corner sequences, a probe table, and
// randomized traffic against a queue-based reference model.
module tb_wt_store_buffer;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        st_valid_i, st_ready_o;
  logic [63:0] st_addr_i, st_data_i;
  logic [7:0]  st_be_i;
  logic        mem_valid_o, mem_ready_i;
  logic [63:0] mem_addr_o, mem_data_o;
  logic [7:0]  mem_be_o;
  logic [1:0]  mem_tid_o;
  logic        mem_rsp_valid_i;
  logic [1:0]  mem_rsp_tid_i;
  logic [63:0] chk_addr_i;
  logic        chk_hit_o, empty_o, full_o;

  wt_store_buffer #(.DEPTH(8), .TID_W(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .st_valid_i(st_valid_i), .st_ready_o(st_ready_o), .st_addr_i(st_addr_i),
    .st_data_i(st_data_i), .st_be_i(st_be_i),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_be_o(mem_be_o), .mem_tid_o(mem_tid_o),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_tid_i(mem_rsp_tid_i),
    .chk_addr_i(chk_addr_i), .chk_hit_o(chk_hit_o), .empty_o(empty_o), .full_o(full_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tot = 0, n_pass = 0;

  typedef struct {logic [63:0] addr; logic hit;} vec_t;
  vec_t tbl[8];

  typedef struct {logic [60:0] w; logic [63:0] d; logic [7:0] be; int st; int tid;} ment_t;
  ment_t mq[$];
  int       m_iss;
  logic [3:0] m_busy;
  bit       m_hold;
  int       m_htid;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic store(input logic [63:0] a, input logic [63:0] d, input logic [7:0] be);
    st_valid_i = 1'b1; st_addr_i = a; st_data_i = d; st_be_i = be;
    step();
    st_valid_i = 1'b0;
  endtask

  task automatic ack(input int t);
    mem_rsp_valid_i = 1'b1; mem_rsp_tid_i = 2'(t);
    step();
    mem_rsp_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; st_valid_i = 1'b0; mem_ready_i = 1'b0; mem_rsp_valid_i = 1'b0;
    step();
    rst_i = 1'b0;
    step();
  endtask

  function automatic logic [63:0] bmask(input logic [7:0] be);
    logic [63:0] m;
    for (int b = 0; b < 8; b++) m[b*8 +: 8] = {8{be[b]}};
    return m;
  endfunction

  initial begin
    logic [63:0] d1, d2, d3;
    tbl[0] = '{64'h2000, 1'b1};
    tbl[1] = '{64'h2007, 1'b1};
    tbl[2] = '{64'h2008, 1'b0};
    tbl[3] = '{64'h1FF8, 1'b0};
    tbl[4] = '{64'h1FFF, 1'b0};
    tbl[5] = '{64'hA000_2000, 1'b0};
    tbl[6] = '{64'h3017, 1'b1};
    tbl[7] = '{64'h3018, 1'b0};

    rst_i = 1'b1; st_valid_i = 1'b0; st_addr_i = '0; st_data_i = '0; st_be_i = '0;
    mem_ready_i = 1'b0; mem_rsp_valid_i = 1'b0; mem_rsp_tid_i = '0; chk_addr_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    // Reset values, with a store and a probe pending on the inputs
    chk_addr_i = 64'h8000_0010; st_valid_i = 1'b1; st_addr_i = 64'h8000_0010; st_be_i = 8'hFF;
    #1;
    chk("rst_st_ready", st_ready_o, 1);
    chk("rst_mem_valid", mem_valid_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_mem_data", mem_data_o, 0);
    chk("rst_mem_be", mem_be_o, 0);
    chk("rst_mem_tid", mem_tid_o, 0);
    chk("rst_chk_hit", chk_hit_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_full", full_o, 0);
    st_valid_i = 1'b0; rst_i = 1'b0;
    step();

    // Single store round trip
    mem_ready_i = 1'b1;
    st_valid_i = 1'b1; st_addr_i = 64'h8000_0010; st_data_i = 64'h11; st_be_i = 8'h01;
    #1;
    chk("single_latency", mem_valid_o, 0);
    step();
    st_valid_i = 1'b0;
    #1;
    chk("single_valid", mem_valid_o, 1);
    chk("single_addr", mem_addr_o, 64'h8000_0010);
    chk("single_data", mem_data_o, 64'h11);
    chk("single_be", mem_be_o, 8'h01);
    chk("single_tid", mem_tid_o, 0);
    step();
    mem_ready_i = 1'b0;
    #1;
    chk("single_sent", mem_valid_o, 0);
    ack(0);
    #1;
    chk("single_done_not_empty", empty_o, 0);
    step();
    chk("single_empty", empty_o, 1);

    // Merge only into an entry not being presented
    do_reset();
    d1 = 64'h1111_2222_3333_4444; d2 = 64'hAAAA_BBBB_CCCC_DDDD; d3 = 64'h0000_0000_0000_5A00;
    store(64'h100, d1, 8'h0F);
    store(64'h104, d2, 8'hF0);
    store(64'h103, d3, 8'h02);
    #1;
    chk("merge_hold_valid", mem_valid_o, 1);
    chk("merge_hold_be", mem_be_o, 8'h0F);
    chk("merge_hold_addr", mem_addr_o, 64'h100);
    mem_ready_i = 1'b1;
    #1;
    chk("merge_e0_data", mem_data_o, d1);
    step();
    #1;
    chk("merge_e1_valid", mem_valid_o, 1);
    chk("merge_e1_addr", mem_addr_o, 64'h100);
    chk("merge_e1_be", mem_be_o, 8'hF2);
    chk("merge_e1_data", mem_data_o, (d2 & ~bmask(8'h02)) | (d3 & bmask(8'h02)));
    chk("merge_e1_tid", mem_tid_o, 1);
    step();
    #1;
    chk("merge_no_third", mem_valid_o, 0);

    // Fill to full, hold a ninth store, release one slot
    do_reset();
    for (int k = 0; k < 8; k++) store(64'h4000 + 64'(k) * 8, 64'(k), 8'hFF);
    #1;
    chk("full_full", full_o, 1);
    chk("full_not_ready", st_ready_o, 0);
    st_valid_i = 1'b1; st_addr_i = 64'h5000; st_data_i = 64'h99; st_be_i = 8'hFF;
    step();
    #1;
    chk("full_ninth_held", full_o, 1);
    mem_ready_i = 1'b1;
    step();
    mem_ready_i = 1'b0;
    #1;
    chk("full_sent_no_retire", full_o, 1);
    ack(0);
    step();
    chk("full_ready_after_retire", st_ready_o, 1);
    chk("full_cleared", full_o, 0);
    step();
    st_valid_i = 1'b0;
    #1;
    chk("full_ninth_accepted", full_o, 1);

    // Out-of-order acks, in-order retire
    do_reset();
    for (int k = 0; k < 5; k++) store(64'h1000 + 64'(k) * 8, 64'(k), 8'hFF);
    mem_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("ooo_issue_valid", mem_valid_o, 1);
      chk("ooo_issue_tid", mem_tid_o, 64'(k));
      chk("ooo_issue_addr", mem_addr_o, 64'h1000 + 64'(k) * 8);
      step();
    end
    #1;
    chk("ooo_tid_block", mem_valid_o, 0);
    mem_ready_i = 1'b0;
    ack(2);
    #1;
    chk("ooo_reuse_valid", mem_valid_o, 1);
    chk("ooo_reuse_tid", mem_tid_o, 2);
    for (int k = 5; k < 8; k++) store(64'h1000 + 64'(k) * 8, 64'(k), 8'hFF);
    #1;
    chk("ooo_no_retire_ack2", full_o, 1);
    ack(0);
    step();
    chk("ooo_retire_e0", full_o, 0);
    store(64'h1040, 64'h8, 8'hFF);
    #1;
    chk("ooo_refill", full_o, 1);
    ack(3);
    step(); step();
    chk("ooo_no_retire_ack3", full_o, 1);
    ack(1);
    repeat (4) step();
    chk("ooo_retired_some", full_o, 0);
    store(64'h1048, 64'h9, 8'hFF);
    store(64'h1050, 64'hA, 8'hFF);
    #1;
    chk("ooo_count7", full_o, 0);
    store(64'h1058, 64'hB, 8'hFF);
    #1;
    chk("ooo_count8", full_o, 1);

    // Load-hazard probe table
    do_reset();
    store(64'h2000, 64'h1, 8'hFF);
    store(64'h3010, 64'h2, 8'hFF);
    for (int i = 0; i < 8; i++) begin
      chk_addr_i = tbl[i].addr;
      #1;
      chk($sformatf("probe_%0h", tbl[i].addr), chk_hit_o, 64'(tbl[i].hit));
    end
    mem_ready_i = 1'b1;
    step(); step();
    mem_ready_i = 1'b0;
    chk_addr_i = 64'h2007;
    #1;
    chk("probe_sent_hit", chk_hit_o, 1);
    ack(0);
    step();
    chk("probe_retired", chk_hit_o, 0);
    chk_addr_i = 64'h3017;
    #1;
    chk("probe_other_sent", chk_hit_o, 1);

    // Reset with writes in flight; stale ack ignored
    do_reset();
    for (int k = 0; k < 3; k++) store(64'h7000 + 64'(k) * 8, 64'(k), 8'hFF);
    mem_ready_i = 1'b1;
    repeat (3) step();
    mem_ready_i = 1'b0;
    #1;
    chk("midrst_all_sent", mem_valid_o, 0);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    ack(1);
    #1;
    chk("midrst_empty", empty_o, 1);
    chk("midrst_valid", mem_valid_o, 0);
    store(64'h6000, 64'h5, 8'hFF);
    #1;
    chk("midrst_tid_free", mem_tid_o, 0);
    chk("midrst_new_valid", mem_valid_o, 1);

    // Randomized traffic against the reference model
    do_reset();
    mq.delete(); m_iss = 0; m_busy = '0; m_hold = 0; m_htid = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      int cnt, lf, e_tid, rt, mj;
      bit sv, rdy, rv, e_rdy, e_valid, e_hit, acc, fire, rok, ret;
      logic [63:0] sa, sd, ca;
      logic [7:0] sbe;
      sv  = ($urandom_range(0, 1) == 1);
      sa  = 64'h1000 + 64'($urandom_range(0, 4)) * 8 + 64'($urandom_range(0, 7));
      sd  = {$urandom, $urandom};
      sbe = 8'($urandom_range(0, 255));
      rdy = ($urandom_range(0, 1) == 1);
      rv  = ($urandom_range(0, 99) < 40);
      rt  = $urandom_range(0, 3);
      ca  = 64'h1000 + 64'($urandom_range(0, 5)) * 8 + 64'($urandom_range(0, 7));
      st_valid_i = sv; st_addr_i = sa; st_data_i = sd; st_be_i = sbe;
      mem_ready_i = rdy; mem_rsp_valid_i = rv; mem_rsp_tid_i = 2'(rt); chk_addr_i = ca;
      #1;
      cnt = mq.size();
      e_rdy = (cnt != 8);
      e_valid = (m_iss < cnt) && (m_busy != 4'hF);
      lf = 0;
      for (int t = 3; t >= 0; t--) if (!m_busy[t]) lf = t;
      e_tid = m_hold ? m_htid : lf;
      e_hit = 0;
      foreach (mq[j]) if (mq[j].st < 2 && mq[j].w == ca[63:3]) e_hit = 1;
      chk("rnd_st_ready", st_ready_o, 64'(e_rdy));
      chk("rnd_empty", empty_o, 64'(cnt == 0));
      chk("rnd_full", full_o, 64'(cnt == 8));
      chk("rnd_chk_hit", chk_hit_o, 64'(e_hit));
      chk("rnd_mem_valid", mem_valid_o, 64'(e_valid));
      if (e_valid) begin
        chk("rnd_mem_addr", mem_addr_o, {mq[m_iss].w, 3'b000});
        chk("rnd_mem_data", mem_data_o, mq[m_iss].d);
        chk("rnd_mem_be", mem_be_o, 64'(mq[m_iss].be));
        chk("rnd_mem_tid", mem_tid_o, 64'(e_tid));
      end
      acc  = sv && e_rdy;
      fire = e_valid && rdy;
      rok  = rv && m_busy[rt];
      ret  = (cnt > 0) && (mq[0].st == 2);
      mj = -1;
      if (acc)
        for (int j = m_iss; j < cnt; j++)
          if (mq[j].w == sa[63:3] && !(j == m_iss && e_valid)) mj = j;
      if (rok) begin
        foreach (mq[j]) if (mq[j].st == 1 && mq[j].tid == rt) mq[j].st = 2;
        m_busy[rt] = 1'b0;
      end
      if (fire) begin
        mq[m_iss].st = 1; mq[m_iss].tid = e_tid; m_busy[e_tid] = 1'b1; m_iss++;
      end
      m_hold = e_valid && !rdy;
      m_htid = e_tid;
      if (acc) begin
        if (mj >= 0) begin
          mq[mj].d  = (mq[mj].d & ~bmask(sbe)) | (sd & bmask(sbe));
          mq[mj].be = mq[mj].be | sbe;
        end else begin
          mq.push_back('{sa[63:3], sd, sbe, 0, 0});
        end
      end
      if (ret) begin
        void'(mq.pop_front());
        m_iss--;
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
